// File: rtl/nibble_packer_pkg.sv
// Shared types and constants for the nibble packer and the nibble selector.
package nibble_packer_pkg;

    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned SEL_WORD_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Nibble selector: nibble idx of a packed word, nibble 0 in the LSBs.
    function automatic logic [NIBBLE_W-1:0] nibble_select(
        input logic [SEL_WORD_W-1:0] word,
        input logic [2:0]            idx
    );
        return word[idx*NIBBLE_W +: NIBBLE_W];
    endfunction

endpackage

// File: rtl/nibble_packer_if.sv
// Nibble input stream plus packed-word output stream of the nibble packer.
interface nibble_packer_if #(
    parameter int WORD_W = 32
);
    import nibble_packer_pkg::*;

    logic [NIBBLE_W-1:0] nibbleIn;
    logic                nibbleValid;
    logic                nibbleReady;
    logic                flush;
    logic [WORD_W-1:0]   dataOut;
    logic [3:0]          dataCount;
    logic                dataValid;
    logic                dataReady;

    // Producer of nibbles / consumer of words.
    modport master (
        output nibbleIn, nibbleValid, flush, dataReady,
        input  nibbleReady, dataOut, dataCount, dataValid
    );

    // The packer itself.
    modport slave (
        input  nibbleIn, nibbleValid, flush, dataReady,
        output nibbleReady, dataOut, dataCount, dataValid
    );

endinterface

// File: rtl/nibble_out_reg.sv
// Single valid/ready holding register for packed words.
module nibble_out_reg #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_data,
    input  logic [3:0]        load_count,
    output logic              load_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [3:0]        out_count,
    output logic              out_valid,
    input  logic              out_ready
);

    // Can take a new word when empty or when the held word drains this cycle.
    assign load_ready = !out_valid || out_ready;

    // Load, drain, or hold; data stays stable while waiting on out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else if (load_valid && load_ready) begin
            out_data  <= load_data;
            out_count <= load_count;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nibble_packer.sv
// Packs 4-bit nibbles into WORD_W-bit words, nibble 0 in the LSBs, with flush.
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter int NIBBLES = 8,
    parameter int WORD_W  = 32
) (
    input logic             clk,
    input logic             reset,
    nibble_packer_if.slave  bus
);

    localparam logic [3:0] LAST_IDX = 4'(NIBBLES - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic [WORD_W-1:0] word;

    logic              nibble_ready;
    logic              accept;
    logic              word_done;
    logic              load_ready;
    logic [WORD_W-1:0] acc_word;
    logic [3:0]        acc_cnt;

    assign nibble_ready    = (state != FULL);
    assign bus.nibbleReady = nibble_ready;
    assign accept          = bus.nibbleValid && nibble_ready;

    // Accumulator view including this cycle's nibble, and word completion.
    always_comb begin
        acc_word = word;
        acc_cnt  = cnt;
        if (accept) begin
            for (int unsigned k = 0; k < NIBBLES; k++) begin
                if (k == 32'(cnt)) begin
                    acc_word[k*NIBBLE_W +: NIBBLE_W] = bus.nibbleIn;
                end
            end
            acc_cnt = cnt + 4'd1;
        end
        word_done = (state == FULL)
                 || (accept && (cnt == LAST_IDX))
                 || (bus.flush && (acc_cnt != 4'd0));
    end

    // State machine and accumulator; cnt keeps the real fill count while
    // stalled in FULL so a held partial word still reports its size.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            cnt   <= '0;
            word  <= '0;
        end else if (word_done) begin
            if (load_ready) begin
                state <= EMPTY;
                cnt   <= '0;
                word  <= '0;
            end else begin
                state <= FULL;
                cnt   <= acc_cnt;
                word  <= acc_word;
            end
        end else begin
            state <= (acc_cnt == 4'd0) ? EMPTY : FILL;
            cnt   <= acc_cnt;
            word  <= acc_word;
        end
    end

    nibble_out_reg #(
        .WORD_W (WORD_W)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .load_valid (word_done),
        .load_data  (acc_word),
        .load_count (acc_cnt),
        .load_ready (load_ready),
        .out_data   (bus.dataOut),
        .out_count  (bus.dataCount),
        .out_valid  (bus.dataValid),
        .out_ready  (bus.dataReady)
    );

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer with hand-computed expected words.
module tb_nibble_packer;
    import nibble_packer_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    nibble_packer_if #(.WORD_W(32)) bus ();

    nibble_packer #(
        .NIBBLES (8),
        .WORD_W  (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] n, input logic fl);
        bus.nibbleValid = 1'b1;
        bus.nibbleIn    = n;
        bus.flush       = fl;
        tick();
        bus.nibbleValid = 1'b0;
        bus.flush       = 1'b0;
    endtask

    logic [3:0] sel_exp [8];

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        bus.nibbleIn    = '0;
        bus.nibbleValid = 1'b0;
        bus.flush       = 1'b0;
        bus.dataReady   = 1'b0;
        sel_exp = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};

        // Reset state
        tick();
        tick();
        check_val("rst_valid", 32'(bus.dataValid), 32'd0);
        check_val("rst_data", bus.dataOut, 32'h0);
        check_val("rst_count", 32'(bus.dataCount), 32'd0);
        reset = 1'b0;
        tick();
        check_val("rst_ready", 32'(bus.nibbleReady), 32'd1);

        // Full word 1..8, output free
        bus.dataReady = 1'b1;
        for (int i = 1; i <= 7; i++) push(4'(i), 1'b0);
        check_val("full_pre_valid", 32'(bus.dataValid), 32'd0);
        push(4'd8, 1'b0);
        check_val("full_valid", 32'(bus.dataValid), 32'd1);
        check_val("full_data", bus.dataOut, 32'h87654321);
        check_val("full_count", 32'(bus.dataCount), 32'd8);
        tick();
        check_val("full_drained", 32'(bus.dataValid), 32'd0);

        // Partial A,B,C then flush, consumer stalled
        bus.dataReady = 1'b0;
        push(4'hA, 1'b0);
        push(4'hB, 1'b0);
        push(4'hC, 1'b0);
        check_val("part_pre_valid", 32'(bus.dataValid), 32'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check_val("part_valid", 32'(bus.dataValid), 32'd1);
        check_val("part_data", bus.dataOut, 32'h00000CBA);
        check_val("part_count", 32'(bus.dataCount), 32'd3);
        tick();
        check_val("part_hold_data", bus.dataOut, 32'h00000CBA);
        check_val("part_hold_count", 32'(bus.dataCount), 32'd3);
        bus.dataReady = 1'b1;
        tick();
        check_val("part_drained", 32'(bus.dataValid), 32'd0);

        // Flush together with an accepted nibble
        push(4'h4, 1'b0);
        push(4'h5, 1'b1);
        check_val("flnib_data", bus.dataOut, 32'h00000054);
        check_val("flnib_count", 32'(bus.dataCount), 32'd2);
        tick();

        // Flush with the 8th nibble, then flush at cnt = 0
        for (int i = 1; i <= 7; i++) push(4'(i), 1'b0);
        push(4'd8, 1'b1);
        check_val("fl8_valid", 32'(bus.dataValid), 32'd1);
        check_val("fl8_data", bus.dataOut, 32'h87654321);
        check_val("fl8_count", 32'(bus.dataCount), 32'd8);
        tick();
        check_val("fl8_no_extra", 32'(bus.dataValid), 32'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check_val("fl0_valid", 32'(bus.dataValid), 32'd0);
        tick();
        check_val("fl0_valid2", 32'(bus.dataValid), 32'd0);

        // 16 nibbles with consumer stalled: one held, one in FULL
        bus.dataReady = 1'b0;
        for (int i = 0; i < 16; i++) push(4'(i), 1'b0);
        check_val("stall_valid", 32'(bus.dataValid), 32'd1);
        check_val("stall_data", bus.dataOut, 32'h76543210);
        check_val("stall_ready", 32'(bus.nibbleReady), 32'd0);
        bus.nibbleValid = 1'b1;
        bus.nibbleIn    = 4'h5;
        bus.flush       = 1'b1;
        tick();
        bus.nibbleValid = 1'b0;
        bus.flush       = 1'b0;
        check_val("stall17_ready", 32'(bus.nibbleReady), 32'd0);
        check_val("stall17_data", bus.dataOut, 32'h76543210);
        bus.dataReady = 1'b1;
        tick();
        check_val("rel_valid", 32'(bus.dataValid), 32'd1);
        check_val("rel_data", bus.dataOut, 32'hFEDCBA98);
        check_val("rel_count", 32'(bus.dataCount), 32'd8);
        check_val("rel_ready", 32'(bus.nibbleReady), 32'd1);
        tick();
        check_val("rel_drained", 32'(bus.dataValid), 32'd0);

        // Reset mid-word with a word pending, overriding other inputs
        bus.dataReady = 1'b0;
        for (int i = 0; i < 8; i++) push(4'hE, 1'b0);
        for (int i = 0; i < 5; i++) push(4'h3, 1'b0);
        check_val("pre_rst_valid", 32'(bus.dataValid), 32'd1);
        reset           = 1'b1;
        bus.nibbleValid = 1'b1;
        bus.nibbleIn    = 4'h7;
        bus.flush       = 1'b1;
        bus.dataReady   = 1'b1;
        tick();
        reset           = 1'b0;
        bus.nibbleValid = 1'b0;
        bus.flush       = 1'b0;
        check_val("mid_rst_valid", 32'(bus.dataValid), 32'd0);
        check_val("mid_rst_ready", 32'(bus.nibbleReady), 32'd1);
        check_val("mid_rst_count", 32'(bus.dataCount), 32'd0);
        tick();
        check_val("post_rst_valid", 32'(bus.dataValid), 32'd0);
        push(4'h9, 1'b0);
        push(4'hA, 1'b0);
        push(4'hB, 1'b0);
        push(4'hC, 1'b0);
        push(4'hD, 1'b0);
        push(4'hE, 1'b0);
        push(4'hF, 1'b0);
        push(4'h1, 1'b0);
        check_val("clean_data", bus.dataOut, 32'h1FEDCBA9);
        check_val("clean_count", 32'(bus.dataCount), 32'd8);
        tick();

        // Round trip through the selector
        bus.dataReady = 1'b0;
        push(4'hF, 1'b0);
        push(4'hE, 1'b0);
        push(4'hE, 1'b0);
        push(4'hB, 1'b0);
        push(4'hD, 1'b0);
        push(4'hA, 1'b0);
        push(4'hE, 1'b0);
        push(4'hD, 1'b0);
        check_val("rt_word", bus.dataOut, 32'hDEADBEEF);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("rt_sel%0d", i),
                      32'(nibble_select(bus.dataOut, 3'(i))), 32'(sel_exp[i]));
        end
        bus.dataReady = 1'b1;
        tick();
        check_val("rt_drained", 32'(bus.dataValid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
